bcd_counter_fsm: RTL

- Parametrised multi-digit BCD up/down counter, controlled by a small state machine.
- Successor to the single-bit enable-driven FSM in the BCD decoder practice.
- Drives DIGITS packed BCD nibbles straight into the existing per-digit BCD-to-7-segment decoders.
- Adds: direction control, parallel load, wrap or saturate mode, terminal-count pulse, invalid-digit flag.

---
 rtl/bcd_counter_fsm.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bcd_counter_fsm.sv
// Multi-digit BCD up/down counter with parallel load, wrap or saturate limits,
// a registered terminal-count pulse and an invalid-load-digit flag.
module bcd_counter_fsm #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_a_p,
  input  logic                  enable,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  tc,
  output logic                  load_err,
  output logic [1:0]            state_o
);

  localparam int DATA_W = 4 * DIGITS;
  localparam logic [DATA_W-1:0] ALL_NINES = {DIGITS{4'h9}};
  localparam logic [DATA_W-1:0] ALL_ZEROS = '0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t            state_p0, state_nxt;
  logic [DATA_W-1:0] bcd_p0, bcd_nxt;
  logic              tc_p0, tc_nxt;
  logic              err_p0, err_nxt;

  logic [DATA_W:0]   step_w;
  logic [DATA_W:0]   load_w;
  logic              at_limit;
  logic              hits_limit;

  // Clamp every nibble above 9 down to 9; MSB of the result flags a clamp.
  function automatic logic [DATA_W:0] sat_load(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    logic              bad;
    r   = v;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
        bad         = 1'b1;
      end
    end
    return {bad, r};
  endfunction

  // One BCD step with full ripple; MSB of the result is the carry/borrow out
  // of the top digit, i.e. the counter wrapped.
  function automatic logic [DATA_W:0] bcd_step(input logic [DATA_W-1:0] v,
                                               input logic              up);
    logic [DATA_W-1:0] r;
    logic              c;
    logic [3:0]        d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (up) begin
          if (d >= 4'd9) begin
            r[4*i +: 4] = 4'd0;
            c           = 1'b1;
          end else begin
            r[4*i +: 4] = d + 4'd1;
            c           = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            r[4*i +: 4] = 4'd9;
            c           = 1'b1;
          end else begin
            r[4*i +: 4] = d - 4'd1;
            c           = 1'b0;
          end
        end
      end
    end
    return {c, r};
  endfunction

  assign step_w     = bcd_step(bcd_p0, up_dn);
  assign load_w     = sat_load(load_val);
  assign at_limit   = up_dn ? (bcd_p0 == ALL_NINES) : (bcd_p0 == ALL_ZEROS);
  assign hits_limit = up_dn ? (step_w[DATA_W-1:0] == ALL_NINES)
                            : (step_w[DATA_W-1:0] == ALL_ZEROS);

  always_comb begin
    state_nxt = state_p0;
    bcd_nxt   = bcd_p0;
    tc_nxt    = 1'b0;
    err_nxt   = 1'b0;
    if (load) begin
      bcd_nxt   = load_w[DATA_W-1:0];
      err_nxt   = load_w[DATA_W];
      state_nxt = enable ? RUN : IDLE;
    end else if (state_p0 != DONE) begin
      if (!enable) begin
        state_nxt = IDLE;
      end else if (WRAP) begin
        state_nxt = RUN;
        bcd_nxt   = step_w[DATA_W-1:0];
        tc_nxt    = step_w[DATA_W];
      end else if (at_limit) begin
        // Already parked on the limit: stay put but still report the event.
        state_nxt = DONE;
        tc_nxt    = 1'b1;
      end else begin
        state_nxt = hits_limit ? DONE : RUN;
        bcd_nxt   = step_w[DATA_W-1:0];
        tc_nxt    = hits_limit;
      end
    end
  end

  // Stage p0: counter value, state and the two event pulses.
  always_ff @(posedge clk) begin
    if (rst_a_p) begin
      state_p0 <= IDLE;
      bcd_p0   <= '0;
      tc_p0    <= 1'b0;
      err_p0   <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      bcd_p0   <= bcd_nxt;
      tc_p0    <= tc_nxt;
      err_p0   <= err_nxt;
    end
  end

  assign bcd_out  = bcd_p0;
  assign tc       = tc_p0;
  assign load_err = err_p0;
  assign state_o  = state_p0;

endmodule
